// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver states.
package uart_pkg;

  localparam int unsigned DEFAULT_CYCLES_PER_BIT = 434;
  localparam int unsigned FRAME_DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial-in / byte-out signal bundle of the UART receiver.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                             i_rx;
  logic [FRAME_DATA_BITS-1:0]       o_data;
  logic                             o_valid;
  logic                             o_frame_err;
  logic                             o_busy;

  // slave: the receiver itself; master: line driver and byte consumer
  modport slave  (input  i_rx, output o_data, output o_valid, output o_frame_err, output o_busy);
  modport master (output i_rx, input  o_data, input  o_valid, input  o_frame_err, input  o_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic r_reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (r_reset) chain <= '1;
    else         chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit data sampling,
// stop-bit check with a one-cycle valid or frame-error strobe.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            r_reset,
  uart_receiver_if.slave  rx_if
);

  localparam int unsigned CYC_W = $clog2(CYCLES_PER_BIT);
  localparam int unsigned HALF  = CYCLES_PER_BIT / 2;
  localparam int unsigned IDX_W = $clog2(FRAME_DATA_BITS);

  localparam logic [CYC_W-1:0] CYC_HALF_LAST = CYC_W'(HALF - 1);
  localparam logic [CYC_W-1:0] CYC_BIT_LAST  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(FRAME_DATA_BITS - 1);

  logic rx_s;

  rx_state_e                  state, state_nx;
  logic [CYC_W-1:0]           cyc, cyc_nx;
  logic [IDX_W-1:0]           bit_idx, bit_idx_nx;
  logic [FRAME_DATA_BITS-1:0] shreg, shreg_nx;
  logic [FRAME_DATA_BITS-1:0] data_q, data_nx;
  logic                       valid_q, valid_nx;
  logic                       ferr_q, ferr_nx;
  logic                       busy_q;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .r_reset  (r_reset),
    .async_in (rx_if.i_rx),
    .sync_out (rx_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    cyc_nx     = cyc + CYC_W'(1);
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    data_nx    = data_q;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        cyc_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: begin
        // A start bit must still be low half a bit later; otherwise it was a glitch.
        if (cyc == CYC_HALF_LAST) begin
          cyc_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc == CYC_BIT_LAST) begin
          cyc_nx            = '0;
          shreg_nx[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) state_nx   = STOP;
          else                     bit_idx_nx = bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
        if (cyc == CYC_BIT_LAST) begin
          cyc_nx = '0;
          if (rx_s) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cyc_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: begin
        cyc_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cyc     <= cyc_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ferr_q  <= ferr_nx;
      busy_q  <= (state_nx != IDLE);
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_busy      = busy_q;

endmodule
